// File: rtl/vga_mode_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : vga_mode_ctrl
//  Purpose  : Reprograms a VGA timing generator from a fixed 4-entry mode
//             table. Swaps are aligned to end of frame, blanking is held over
//             the swap plus a number of settle frames, and each request is
//             acknowledged with a one-cycle pulse.
//  Revision : 1.0 - initial release
// ============================================================================
module vga_mode_ctrl #(
  parameter int H_W           = 12,
  parameter int V_W           = 11,
  parameter int SETTLE_FRAMES = 1
) (
  input  logic           clk_i,
  input  logic           arstn_i,
  input  logic           mode_req_i,
  input  logic [1:0]     mode_sel_i,
  output logic           mode_ack_o,
  output logic           busy_o,
  output logic [1:0]     cur_mode_o,
  input  logic [H_W-1:0] hcount_i,
  input  logic [V_W-1:0] vcount_i,
  output logic [H_W-1:0] hd_o,
  output logic [H_W-1:0] hf_o,
  output logic [H_W-1:0] hr_o,
  output logic [H_W-1:0] hb_o,
  output logic [V_W-1:0] vd_o,
  output logic [V_W-1:0] vf_o,
  output logic [V_W-1:0] vr_o,
  output logic [V_W-1:0] vb_o,
  output logic           we_o,
  output logic           blank_o
);

  typedef enum logic [2:0] {
    S_INIT     = 3'd0,
    S_IDLE     = 3'd1,
    S_WAIT_EOF = 3'd2,
    S_LOAD     = 3'd3,
    S_SETTLE   = 3'd4,
    S_ACK      = 3'd5
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [1:0]     r_pend;
  logic [1:0]     r_cur;
  logic [H_W-1:0] r_hd, r_hf, r_hr, r_hb, r_htot;
  logic [V_W-1:0] r_vd, r_vf, r_vr, r_vb, r_vtot;
  logic [3:0]     r_settle_cnt;

  logic [H_W-1:0] w_hd, w_hf, w_hr, w_hb;
  logic [V_W-1:0] w_vd, w_vf, w_vr, w_vb;
  logic           w_eof;
  logic           w_settle_done;

  // Last pixel of the frame, judged against the totals of the active mode
  assign w_eof = (hcount_i == r_htot - H_W'(1)) && (vcount_i == r_vtot - V_W'(1));

  // The eof that completes the settle count; zero settle frames never waits
  assign w_settle_done = (SETTLE_FRAMES == 0) ||
                         (w_eof && (({1'b0, r_settle_cnt} + 5'd1) == 5'(SETTLE_FRAMES)));

  // Mode table lookup for the pending mode
  always_comb begin
    w_hd = '0; w_hf = '0; w_hr = '0; w_hb = '0;
    w_vd = '0; w_vf = '0; w_vr = '0; w_vb = '0;
    case (r_pend)
      2'd0: begin
        w_hd = H_W'(640);  w_hf = H_W'(16); w_hr = H_W'(96);  w_hb = H_W'(48);
        w_vd = V_W'(480);  w_vf = V_W'(10); w_vr = V_W'(2);   w_vb = V_W'(33);
      end
      2'd1: begin
        w_hd = H_W'(800);  w_hf = H_W'(40); w_hr = H_W'(128); w_hb = H_W'(88);
        w_vd = V_W'(600);  w_vf = V_W'(1);  w_vr = V_W'(4);   w_vb = V_W'(23);
      end
      2'd2: begin
        w_hd = H_W'(1024); w_hf = H_W'(24); w_hr = H_W'(136); w_hb = H_W'(160);
        w_vd = V_W'(768);  w_vf = V_W'(3);  w_vr = V_W'(6);   w_vb = V_W'(29);
      end
      2'd3: begin
        w_hd = H_W'(16);   w_hf = H_W'(2);  w_hr = H_W'(4);   w_hb = H_W'(2);
        w_vd = V_W'(8);    w_vf = V_W'(1);  w_vr = V_W'(1);   w_vb = V_W'(1);
      end
      default: ;
    endcase
  end

  // State register; reset always lands in INIT so mode 0 is rewritten
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) r_state <= S_INIT;
    else          r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_INIT:     w_state_nxt = S_SETTLE;
      S_IDLE: begin
        if (mode_req_i) begin
          if (mode_sel_i == r_cur) w_state_nxt = S_ACK;
          else                     w_state_nxt = S_WAIT_EOF;
        end
      end
      S_WAIT_EOF: if (w_eof) w_state_nxt = S_LOAD;
      S_LOAD:     w_state_nxt = S_SETTLE;
      S_SETTLE:   if (w_settle_done) w_state_nxt = S_ACK;
      S_ACK:      w_state_nxt = S_IDLE;
      default:    w_state_nxt = S_INIT;
    endcase
  end

  // Datapath: pending mode, timing registers, totals and settle counter
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      r_pend       <= 2'd0;
      r_cur        <= 2'd0;
      r_hd         <= H_W'(640);
      r_hf         <= H_W'(16);
      r_hr         <= H_W'(96);
      r_hb         <= H_W'(48);
      r_vd         <= V_W'(480);
      r_vf         <= V_W'(10);
      r_vr         <= V_W'(2);
      r_vb         <= V_W'(33);
      r_htot       <= H_W'(800);
      r_vtot       <= V_W'(525);
      r_settle_cnt <= 4'd0;
    end else begin
      // Latch only at acceptance; later mode_sel_i changes are ignored
      if (r_state == S_IDLE && mode_req_i && mode_sel_i != r_cur)
        r_pend <= mode_sel_i;
      // New timings land in the eof cycle so they are stable while we_o is high
      if (r_state == S_WAIT_EOF && w_eof) begin
        r_hd <= w_hd; r_hf <= w_hf; r_hr <= w_hr; r_hb <= w_hb;
        r_vd <= w_vd; r_vf <= w_vf; r_vr <= w_vr; r_vb <= w_vb;
      end
      // Totals switch with the write so settle counts frames of the new mode
      if (r_state == S_LOAD) begin
        r_cur  <= r_pend;
        r_htot <= r_hd + r_hf + r_hr + r_hb;
        r_vtot <= r_vd + r_vf + r_vr + r_vb;
      end
      if (r_state != S_SETTLE) r_settle_cnt <= 4'd0;
      else if (w_eof)          r_settle_cnt <= r_settle_cnt + 4'd1;
    end
  end

  // we_o is gated by reset so the INIT write fires only once reset releases
  assign we_o       = arstn_i && (r_state == S_INIT || r_state == S_LOAD);
  assign mode_ack_o = (r_state == S_ACK);
  assign busy_o     = (r_state != S_IDLE);
  assign blank_o    = !(r_state == S_IDLE || r_state == S_ACK);
  assign cur_mode_o = r_cur;
  assign hd_o = r_hd;
  assign hf_o = r_hf;
  assign hr_o = r_hr;
  assign hb_o = r_hb;
  assign vd_o = r_vd;
  assign vf_o = r_vf;
  assign vr_o = r_vr;
  assign vb_o = r_vb;

endmodule
`default_nettype wire

// File: tb/tb_vga_mode_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_vga_mode_ctrl
//  Purpose  : Directed self-checking bench for vga_mode_ctrl. Two instances:
//             dut0 with one settle frame, dut1 with zero settle frames. A
//             small timing generator per instance restarts on we_o and may be
//             advanced near end of frame to keep runs short.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vga_mode_ctrl;

  logic clk = 1'b0;
  logic arstn;
  always #5 clk = ~clk;

  logic        req0, ack0, busy0, we0, blank0;
  logic [1:0]  sel0, cur0;
  logic [11:0] hc0, hd0, hf0, hr0, hb0;
  logic [10:0] vc0, vd0, vf0, vr0, vb0;
  logic        req1, ack1, busy1, we1, blank1;
  logic [1:0]  sel1, cur1;
  logic [11:0] hc1, hd1, hf1, hr1, hb1;
  logic [10:0] vc1, vd1, vf1, vr1, vb1;

  int n_tests = 0;
  int n_fail  = 0;
  int ht0 = 800, vt0 = 525, ht1 = 800, vt1 = 525;
  int pre_h0, pre_v0, pre_h1, pre_v1;

  vga_mode_ctrl #(.H_W(12), .V_W(11), .SETTLE_FRAMES(1)) dut0 (
    .clk_i(clk), .arstn_i(arstn), .mode_req_i(req0), .mode_sel_i(sel0),
    .mode_ack_o(ack0), .busy_o(busy0), .cur_mode_o(cur0),
    .hcount_i(hc0), .vcount_i(vc0),
    .hd_o(hd0), .hf_o(hf0), .hr_o(hr0), .hb_o(hb0),
    .vd_o(vd0), .vf_o(vf0), .vr_o(vr0), .vb_o(vb0),
    .we_o(we0), .blank_o(blank0)
  );

  vga_mode_ctrl #(.H_W(12), .V_W(11), .SETTLE_FRAMES(0)) dut1 (
    .clk_i(clk), .arstn_i(arstn), .mode_req_i(req1), .mode_sel_i(sel1),
    .mode_ack_o(ack1), .busy_o(busy1), .cur_mode_o(cur1),
    .hcount_i(hc1), .vcount_i(vc1),
    .hd_o(hd1), .hf_o(hf1), .hr_o(hr1), .hb_o(hb1),
    .vd_o(vd1), .vf_o(vf1), .vr_o(vr1), .vb_o(vb1),
    .we_o(we1), .blank_o(blank1)
  );

  // One clock: advance both timing generators, then settle for sampling
  task automatic step();
    logic w0, w1;
    w0 = we0;
    w1 = we1;
    @(posedge clk);
    #1;
    pre_h0 = int'(hc0); pre_v0 = int'(vc0);
    pre_h1 = int'(hc1); pre_v1 = int'(vc1);
    if (w0) begin
      ht0 = int'(hd0) + int'(hf0) + int'(hr0) + int'(hb0);
      vt0 = int'(vd0) + int'(vf0) + int'(vr0) + int'(vb0);
      hc0 = '0; vc0 = '0;
    end else if (int'(hc0) == ht0 - 1) begin
      hc0 = '0;
      vc0 = (int'(vc0) == vt0 - 1) ? 11'd0 : vc0 + 11'd1;
    end else hc0 = hc0 + 12'd1;
    if (w1) begin
      ht1 = int'(hd1) + int'(hf1) + int'(hr1) + int'(hb1);
      vt1 = int'(vd1) + int'(vf1) + int'(vr1) + int'(vb1);
      hc1 = '0; vc1 = '0;
    end else if (int'(hc1) == ht1 - 1) begin
      hc1 = '0;
      vc1 = (int'(vc1) == vt1 - 1) ? 11'd0 : vc1 + 11'd1;
    end else hc1 = hc1 + 12'd1;
  endtask

  task automatic test_reset();
    arstn = 1'b0;
    req0 = 1'b0; sel0 = 2'd0; req1 = 1'b0; sel1 = 2'd0;
    hc0 = '0; vc0 = '0; hc1 = '0; vc1 = '0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if ({we0, ack0, busy0, blank0} !== 4'b0011) begin
      n_fail++; $display("FAIL reset_flags0: got %b want 0011", {we0, ack0, busy0, blank0});
    end
    n_tests++;
    if ({hd0, hf0, hr0, hb0} !== {12'd640, 12'd16, 12'd96, 12'd48} ||
        {vd0, vf0, vr0, vb0} !== {11'd480, 11'd10, 11'd2, 11'd33} || cur0 !== 2'd0) begin
      n_fail++; $display("FAIL reset_timing0: got hd=%0d vd=%0d cur=%0d want 640 480 0", hd0, vd0, cur0);
    end
    n_tests++;
    if ({we1, ack1, busy1, blank1} !== 4'b0011) begin
      n_fail++; $display("FAIL reset_flags1: got %b want 0011", {we1, ack1, busy1, blank1});
    end
    arstn = 1'b1;
    #1;
    n_tests++;
    if (we0 !== 1'b1 || hd0 !== 12'd640 || vd0 !== 11'd480 || cur0 !== 2'd0) begin
      n_fail++; $display("FAIL init_we: got we=%b hd=%0d vd=%0d cur=%0d want 1 640 480 0", we0, hd0, vd0, cur0);
    end
  endtask

  task automatic test_init_settle();
    int k;
    step();
    n_tests++;
    if ({we0, busy0, blank0} !== 3'b011) begin
      n_fail++; $display("FAIL init_settle: got we/busy/blank=%b want 011", {we0, busy0, blank0});
    end
    hc0 = 12'd796; vc0 = 11'd524;
    k = 0;
    while (ack0 !== 1'b1 && k < 50) begin step(); k++; end
    n_tests++;
    if (k != 4 || blank0 !== 1'b0) begin
      n_fail++; $display("FAIL init_ack: got cycles=%0d blank=%b want 4 0", k, blank0);
    end
    step();
    n_tests++;
    if ({ack0, busy0, blank0} !== 3'b000) begin
      n_fail++; $display("FAIL init_idle: got ack/busy/blank=%b want 000", {ack0, busy0, blank0});
    end
  endtask

  task automatic test_same_mode();
    req0 = 1'b1; sel0 = 2'd0;
    step();
    n_tests++;
    if ({ack0, we0, blank0} !== 3'b100 || cur0 !== 2'd0) begin
      n_fail++; $display("FAIL same_mode_ack: got ack/we/blank=%b cur=%0d want 100 0", {ack0, we0, blank0}, cur0);
    end
    req0 = 1'b0;
    step();
    n_tests++;
    if ({ack0, busy0, blank0, we0} !== 4'b0000) begin
      n_fail++; $display("FAIL same_mode_idle: got %b want 0000", {ack0, busy0, blank0, we0});
    end
  endtask

  task automatic test_mode_change();
    int k, early, extra;
    req0 = 1'b1; sel0 = 2'd3;
    step();
    n_tests++;
    if ({busy0, blank0, we0} !== 3'b110 || hd0 !== 12'd640) begin
      n_fail++; $display("FAIL m3_wait: got busy/blank/we=%b hd=%0d want 110 640", {busy0, blank0, we0}, hd0);
    end
    hc0 = 12'd796; vc0 = 11'd524;
    early = 0;
    for (int i = 0; i < 3; i++) begin step(); if (we0 !== 1'b0) early++; end
    n_tests++;
    if (early != 0) begin
      n_fail++; $display("FAIL m3_early_we: got %0d early strobes want 0", early);
    end
    step();
    n_tests++;
    if (we0 !== 1'b1 || pre_h0 != 799 || pre_v0 != 524) begin
      n_fail++; $display("FAIL m3_we_align: got we=%b after h=%0d v=%0d want 1 after 799 524", we0, pre_h0, pre_v0);
    end
    n_tests++;
    if ({hd0, hf0, hr0, hb0} !== {12'd16, 12'd2, 12'd4, 12'd2} ||
        {vd0, vf0, vr0, vb0} !== {11'd8, 11'd1, 11'd1, 11'd1}) begin
      n_fail++; $display("FAIL m3_timing: got hd=%0d vd=%0d want 16 8", hd0, vd0);
    end
    k = 0; extra = 0;
    while (ack0 !== 1'b1 && k < 400) begin step(); k++; if (we0 === 1'b1) extra++; end
    n_tests++;
    if (k != 265 || extra != 0) begin
      n_fail++; $display("FAIL m3_latency: got %0d cycles extra_we=%0d want 265 0", k, extra);
    end
    n_tests++;
    if (cur0 !== 2'd3) begin
      n_fail++; $display("FAIL m3_cur: got %0d want 3", cur0);
    end
    req0 = 1'b0; sel0 = 2'd0;
    step();
  endtask

  task automatic test_sel_change();
    int k;
    req0 = 1'b1; sel0 = 2'd2;
    step();
    sel0 = 2'd1;
    hc0 = 12'd20; vc0 = 11'd10;
    k = 0;
    while (we0 !== 1'b1 && k < 50) begin step(); k++; end
    n_tests++;
    if (k != 4 || pre_h0 != 23 || pre_v0 != 10 || hd0 !== 12'd1024 || vd0 !== 11'd768) begin
      n_fail++; $display("FAIL selchg_load: got k=%0d h=%0d v=%0d hd=%0d vd=%0d want 4 23 10 1024 768",
                         k, pre_h0, pre_v0, hd0, vd0);
    end
    step();
    hc0 = 12'd1340; vc0 = 11'd805;
    k = 0;
    while (ack0 !== 1'b1 && k < 50) begin step(); k++; end
    n_tests++;
    if (k != 4 || cur0 !== 2'd2) begin
      n_fail++; $display("FAIL selchg_ack: got k=%0d cur=%0d want 4 2", k, cur0);
    end
    req0 = 1'b0;
    step();
  endtask

  task automatic test_reset_in_settle();
    int k, acks;
    req0 = 1'b1; sel0 = 2'd3;
    step();
    hc0 = 12'd1340; vc0 = 11'd805;
    k = 0;
    while (we0 !== 1'b1 && k < 50) begin step(); k++; end
    step();
    n_tests++;
    if ({busy0, blank0, ack0} !== 3'b110 || cur0 !== 2'd3) begin
      n_fail++; $display("FAIL rst_pre_settle: got busy/blank/ack=%b cur=%0d want 110 3", {busy0, blank0, ack0}, cur0);
    end
    #2;
    arstn = 1'b0;
    #1;
    n_tests++;
    if ({we0, ack0, busy0, blank0} !== 4'b0011 || cur0 !== 2'd0 || hd0 !== 12'd640) begin
      n_fail++; $display("FAIL rst_async: got flags=%b cur=%0d hd=%0d want 0011 0 640",
                         {we0, ack0, busy0, blank0}, cur0, hd0);
    end
    req0 = 1'b0; sel0 = 2'd0;
    acks = 0;
    for (int i = 0; i < 3; i++) begin step(); if (ack0 !== 1'b0) acks++; end
    arstn = 1'b1;
    #1;
    n_tests++;
    if (acks != 0 || we0 !== 1'b1 || cur0 !== 2'd0 || vd0 !== 11'd480) begin
      n_fail++; $display("FAIL rst_release: got acks=%0d we=%b cur=%0d vd=%0d want 0 1 0 480", acks, we0, cur0, vd0);
    end
    step();
    hc0 = 12'd796; vc0 = 11'd524;
    k = 0;
    while (ack0 !== 1'b1 && k < 50) begin step(); k++; end
    n_tests++;
    if (k != 4 || cur0 !== 2'd0) begin
      n_fail++; $display("FAIL rst_reinit: got k=%0d cur=%0d want 4 0", k, cur0);
    end
    step();
  endtask

  task automatic test_back_to_back();
    int k;
    req1 = 1'b1; sel1 = 2'd3;
    step();
    hc1 = 12'd797; vc1 = 11'd524;
    k = 0;
    while (we1 !== 1'b1 && k < 50) begin step(); k++; end
    n_tests++;
    if (k != 3 || pre_h1 != 799 || pre_v1 != 524 || hd1 !== 12'd16) begin
      n_fail++; $display("FAIL b2b_load1: got k=%0d h=%0d v=%0d hd=%0d want 3 799 524 16", k, pre_h1, pre_v1, hd1);
    end
    step();
    step();
    n_tests++;
    if (ack1 !== 1'b1 || cur1 !== 2'd3 || we1 !== 1'b0) begin
      n_fail++; $display("FAIL b2b_ack1: got ack=%b cur=%0d we=%b want 1 3 0", ack1, cur1, we1);
    end
    sel1 = 2'd2;
    step();
    n_tests++;
    if ({ack1, busy1, blank1} !== 3'b000) begin
      n_fail++; $display("FAIL b2b_idle: got ack/busy/blank=%b want 000", {ack1, busy1, blank1});
    end
    step();
    k = 0;
    while (we1 !== 1'b1 && k < 400) begin step(); k++; end
    n_tests++;
    if (we1 !== 1'b1 || pre_h1 != 23 || pre_v1 != 10 || hd1 !== 12'd1024) begin
      n_fail++; $display("FAIL b2b_load2: got we=%b h=%0d v=%0d hd=%0d want 1 23 10 1024", we1, pre_h1, pre_v1, hd1);
    end
    step();
    step();
    n_tests++;
    if (ack1 !== 1'b1 || cur1 !== 2'd2) begin
      n_fail++; $display("FAIL b2b_ack2: got ack=%b cur=%0d want 1 2", ack1, cur1);
    end
    req1 = 1'b0;
    step();
    n_tests++;
    if (busy1 !== 1'b0 || hd1 !== 12'd1024) begin
      n_fail++; $display("FAIL b2b_final: got busy=%b hd=%0d want 0 1024", busy1, hd1);
    end
  endtask

  initial begin
    test_reset();
    test_init_settle();
    test_same_mode();
    test_mode_change();
    test_sel_change();
    test_reset_in_settle();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
